exc_responder: RTL and testbench
================================

EXC_RESPONDER -- requirements
Module: exc_responder

Interface
REQ-001 SHALL have parameter HANDLER_VECTOR, default 32'h0000_0180, the PC loaded on exception entry.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  the reset; synchronous and active-high.
REQ-004 SHALL have ports EH_overflow, EH_Invalid_addr, EH_Div_zero, EH_control and EH_write2_0  input  1 each  the exception sources from the exception detector.
REQ-005 SHALL have port pc_in  input  32  the PC of the instruction currently in the faulting stage.
REQ-006 SHALL have port eret  input  1  the return-from-exception request from decode.
REQ-007 SHALL have port flush  output  1  the pipeline flush strobe.
REQ-008 SHALL have port pc_redirect  output  1  the signal that the PC mux selects redirect_pc.
REQ-009 SHALL have port redirect_pc  output  32  the target PC.
REQ-010 SHALL have port epc  output  32  the saved exception PC.
REQ-011 SHALL have port cause  output  3  the encoded exception cause.
REQ-012 SHALL have port in_handler  output  1  the signal that the core is executing the handler.
REQ-013 SHALL have port exc_count  output  8  the count of accepted exceptions.
REQ-014 SHALL have port double_fault  output  1  the sticky nested-exception flag.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, REDIRECT, HANDLER and RETURN.
REQ-016 SHALL, in IDLE with any source high at a clk edge, capture epc<=pc_in, capture cause and move to FLUSH (entry accepted).
REQ-017 SHALL encode cause with priority Invalid_addr=3'd2 > Div_zero=3'd3 > overflow=3'd1 > control=3'd4 > write2_0=3'd5; 3'd0 means none.
REQ-018 SHALL assert flush=1 for exactly the one cycle in FLUSH, then move to REDIRECT.
REQ-019 SHALL, in REDIRECT, assert pc_redirect=1 with redirect_pc=HANDLER_VECTOR for one cycle, then move to HANDLER.
REQ-020 SHALL assert in_handler=1 only while in HANDLER; HANDLER persists until eret=1.
REQ-021 SHALL, on eret=1 in HANDLER, move to RETURN; RETURN asserts pc_redirect=1 with redirect_pc=epc for one cycle, then returns to IDLE.
REQ-022 SHALL drive redirect_pc=32'd0 and pc_redirect=0 in all states other than REDIRECT and RETURN.
REQ-023 SHALL give a fixed entry latency: source sampled at edge N, flush high in cycle N+1, redirect high in N+2, in_handler high from N+3.
REQ-024 SHALL ignore sources in FLUSH, REDIRECT and RETURN: no capture, no count.
REQ-025 SHALL, on any source high in HANDLER, set double_fault=1 and leave epc, cause and count unchanged; double_fault stays set until rst.
REQ-026 SHALL give eret precedence over a simultaneous source in HANDLER: move to RETURN, and still set double_fault.
REQ-027 SHALL ignore eret in any state other than HANDLER.
REQ-028 SHALL increment exc_count by 1 per accepted entry, saturating at 8'd255 without wrap.
REQ-029 SHALL hold epc and cause from entry through RETURN and into IDLE until the next accepted entry.

Reset
REQ-030 SHALL, with rst=1 at a clk edge, force state=IDLE and flush, pc_redirect and in_handler=0, redirect_pc, epc and exc_count=0, cause=3'd0 and double_fault=0.
REQ-031 SHALL give rst priority over all inputs in every state; rst mid-sequence (e.g. in REDIRECT) aborts with no further flush or redirect pulses.
REQ-032 SHALL resume: the first edge after rst deasserts evaluates IDLE normally.

Verification
REQ-033 SHALL cover: EH_Div_zero=1 for one cycle, pc_in=32'h0040_0010 -> flush at N+1; pc_redirect with redirect_pc=32'h180 at N+2; in_handler from N+3; epc=32'h0040_0010; cause=3; exc_count=1.
REQ-034 SHALL cover: EH_overflow=1 and EH_Invalid_addr=1 in the same cycle -> cause=2.
REQ-035 SHALL cover: in HANDLER, eret=1 -> next cycle pc_redirect=1 with redirect_pc=epc; the following cycle IDLE with in_handler=0.
REQ-036 SHALL cover: in HANDLER, EH_control=1 -> double_fault=1; cause and epc unchanged; double_fault still 1 after eret and return to IDLE.
REQ-037 SHALL cover: 256 complete entry/eret cycles -> exc_count=255, no wrap.
REQ-038 SHALL cover: rst=1 during REDIRECT -> all outputs 0 on the next cycle; a source one cycle after rst deasserts is accepted normally.

Source files
------------

// File: rtl/exc_responder_if.sv
// Exception responder bus: exception sources and PC from the pipeline in,
// flush/redirect control and exception status out.
interface exc_responder_if;
    logic        EH_overflow;
    logic        EH_Invalid_addr;
    logic        EH_Div_zero;
    logic        EH_control;
    logic        EH_write2_0;
    logic [31:0] pc_in;
    logic        eret;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        in_handler;
    logic [7:0]  exc_count;
    logic        double_fault;

    // Pipeline side: drives the exception sources and observes the response
    modport master (
        output EH_overflow, EH_Invalid_addr, EH_Div_zero, EH_control, EH_write2_0,
        output pc_in, eret,
        input  flush, pc_redirect, redirect_pc, epc, cause, in_handler,
        input  exc_count, double_fault
    );

    // Responder side
    modport slave (
        input  EH_overflow, EH_Invalid_addr, EH_Div_zero, EH_control, EH_write2_0,
        input  pc_in, eret,
        output flush, pc_redirect, redirect_pc, epc, cause, in_handler,
        output exc_count, double_fault
    );
endinterface

// File: rtl/exc_responder.sv
// Exception responder: on an accepted exception it saves the faulting PC and
// cause, flushes the pipeline for one cycle, redirects to the handler vector,
// and on eret redirects back to the saved PC. All outputs are registered.
module exc_responder #(
    parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180
) (
    input logic           clk,
    input logic           rst,
    exc_responder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        REDIRECT,
        HANDLER,
        RETURN
    } state_t;

    state_t      state;
    logic        any_src;
    logic [2:0]  cause_next;
    logic        flush_q;
    logic        pc_redirect_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] epc_q;
    logic [2:0]  cause_q;
    logic        in_handler_q;
    logic [7:0]  exc_count_q;
    logic        double_fault_q;

    assign any_src = bus.EH_overflow | bus.EH_Invalid_addr | bus.EH_Div_zero |
                     bus.EH_control  | bus.EH_write2_0;

    // Priority-encode the exception sources into a cause code
    always_comb begin
        cause_next = 3'd0;
        if (bus.EH_Invalid_addr)  cause_next = 3'd2;
        else if (bus.EH_Div_zero) cause_next = 3'd3;
        else if (bus.EH_overflow) cause_next = 3'd1;
        else if (bus.EH_control)  cause_next = 3'd4;
        else if (bus.EH_write2_0) cause_next = 3'd5;
    end

    // Sequencer: strobes default low each cycle and are raised only by the state that owns them
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flush_q        <= 1'b0;
            pc_redirect_q  <= 1'b0;
            redirect_pc_q  <= 32'd0;
            epc_q          <= 32'd0;
            cause_q        <= 3'd0;
            in_handler_q   <= 1'b0;
            exc_count_q    <= 8'd0;
            double_fault_q <= 1'b0;
        end else begin
            flush_q       <= 1'b0;
            pc_redirect_q <= 1'b0;
            redirect_pc_q <= 32'd0;
            in_handler_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_src) begin
                        epc_q   <= bus.pc_in;
                        cause_q <= cause_next;
                        if (exc_count_q != 8'd255) begin
                            exc_count_q <= exc_count_q + 8'd1;
                        end
                        flush_q <= 1'b1;
                        state   <= FLUSH;
                    end
                end
                FLUSH: begin
                    pc_redirect_q <= 1'b1;
                    redirect_pc_q <= HANDLER_VECTOR;
                    state         <= REDIRECT;
                end
                REDIRECT: begin
                    in_handler_q <= 1'b1;
                    state        <= HANDLER;
                end
                HANDLER: begin
                    if (any_src) begin
                        double_fault_q <= 1'b1;
                    end
                    if (bus.eret) begin
                        pc_redirect_q <= 1'b1;
                        redirect_pc_q <= epc_q;
                        state         <= RETURN;
                    end else begin
                        in_handler_q <= 1'b1;
                    end
                end
                RETURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.flush        = flush_q;
    assign bus.pc_redirect  = pc_redirect_q;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.epc          = epc_q;
    assign bus.cause        = cause_q;
    assign bus.in_handler   = in_handler_q;
    assign bus.exc_count    = exc_count_q;
    assign bus.double_fault = double_fault_q;

endmodule

// File: tb/tb_exc_responder.sv
// Directed testbench for exc_responder. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_exc_responder;

    logic clk;
    logic rst;
    int   errorCount;
    int   checkCount;

    exc_responder_if bus ();

    exc_responder #(.HANDLER_VECTOR(32'h0000_0180)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // src bits: {Invalid_addr, Div_zero, overflow, control, write2_0}
    task automatic applyStimulus(input logic [4:0] src, input logic [31:0] pc, input logic er);
        bus.EH_Invalid_addr = src[4];
        bus.EH_Div_zero     = src[3];
        bus.EH_overflow     = src[2];
        bus.EH_control      = src[1];
        bus.EH_write2_0     = src[0];
        bus.pc_in           = pc;
        bus.eret            = er;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // One full entry / handler / eret / back-to-IDLE sequence
    task automatic runEntry(input logic [4:0] src, input logic [31:0] pc);
        applyStimulus(src, pc, 1'b0);
        nextCycle();
        applyStimulus(5'b0, pc, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(5'b0, pc, 1'b1);
        nextCycle();
        applyStimulus(5'b0, pc, 1'b0);
        nextCycle();
    endtask

    logic [4:0] tableSrc   [7];
    logic [2:0] tableCause [7];

    initial begin
        errorCount = 0;
        checkCount = 0;
        tableSrc[0] = 5'b00001; tableCause[0] = 3'd5;
        tableSrc[1] = 5'b00011; tableCause[1] = 3'd4;
        tableSrc[2] = 5'b00111; tableCause[2] = 3'd1;
        tableSrc[3] = 5'b01111; tableCause[3] = 3'd3;
        tableSrc[4] = 5'b11111; tableCause[4] = 3'd2;
        tableSrc[5] = 5'b10100; tableCause[5] = 3'd2;
        tableSrc[6] = 5'b01010; tableCause[6] = 3'd3;

        applyStimulus(5'b0, 32'd0, 1'b0);
        rst = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("rst_flush",       32'(bus.flush),        32'd0);
        checkOutput("rst_pc_redirect", 32'(bus.pc_redirect),  32'd0);
        checkOutput("rst_redirect_pc", bus.redirect_pc,       32'd0);
        checkOutput("rst_epc",         bus.epc,               32'd0);
        checkOutput("rst_cause",       32'(bus.cause),        32'd0);
        checkOutput("rst_in_handler",  32'(bus.in_handler),   32'd0);
        checkOutput("rst_count",       32'(bus.exc_count),    32'd0);
        checkOutput("rst_dfault",      32'(bus.double_fault), 32'd0);
        rst = 1'b0;
        nextCycle();

        $display("[TB] divide-by-zero entry and return");
        applyStimulus(5'b01000, 32'h0040_0010, 1'b0);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        checkOutput("n1_flush",       32'(bus.flush),       32'd1);
        checkOutput("n1_pc_redirect", 32'(bus.pc_redirect), 32'd0);
        checkOutput("n1_epc",         bus.epc,              32'h0040_0010);
        checkOutput("n1_cause",       32'(bus.cause),       32'd3);
        checkOutput("n1_count",       32'(bus.exc_count),   32'd1);
        nextCycle();
        checkOutput("n2_flush",       32'(bus.flush),       32'd0);
        checkOutput("n2_pc_redirect", 32'(bus.pc_redirect), 32'd1);
        checkOutput("n2_redirect_pc", bus.redirect_pc,      32'h0000_0180);
        checkOutput("n2_in_handler",  32'(bus.in_handler),  32'd0);
        nextCycle();
        checkOutput("n3_in_handler",  32'(bus.in_handler),  32'd1);
        checkOutput("n3_pc_redirect", 32'(bus.pc_redirect), 32'd0);
        checkOutput("n3_redirect_pc", bus.redirect_pc,      32'd0);
        repeat (3) nextCycle();
        checkOutput("hold_in_handler", 32'(bus.in_handler), 32'd1);
        applyStimulus(5'b0, 32'h0, 1'b1);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        checkOutput("ret_pc_redirect", 32'(bus.pc_redirect), 32'd1);
        checkOutput("ret_redirect_pc", bus.redirect_pc,      32'h0040_0010);
        checkOutput("ret_in_handler",  32'(bus.in_handler),  32'd0);
        nextCycle();
        checkOutput("idle_pc_redirect", 32'(bus.pc_redirect), 32'd0);
        checkOutput("idle_in_handler",  32'(bus.in_handler),  32'd0);
        checkOutput("idle_epc_held",    bus.epc,              32'h0040_0010);
        checkOutput("idle_cause_held",  32'(bus.cause),       32'd3);

        $display("[TB] eret outside handler");
        applyStimulus(5'b0, 32'h0, 1'b1);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        checkOutput("idle_eret_redirect", 32'(bus.pc_redirect), 32'd0);
        checkOutput("idle_eret_flush",    32'(bus.flush),       32'd0);

        $display("[TB] simultaneous sources, ignored source, double fault");
        applyStimulus(5'b10100, 32'h0000_1000, 1'b0);
        nextCycle();
        applyStimulus(5'b00001, 32'h0000_2000, 1'b0);
        checkOutput("pri_cause", 32'(bus.cause),     32'd2);
        checkOutput("pri_epc",   bus.epc,            32'h0000_1000);
        checkOutput("pri_count", 32'(bus.exc_count), 32'd2);
        nextCycle();
        applyStimulus(5'b0, 32'h0000_2000, 1'b0);
        checkOutput("ign_cause", 32'(bus.cause),     32'd2);
        checkOutput("ign_epc",   bus.epc,            32'h0000_1000);
        checkOutput("ign_count", 32'(bus.exc_count), 32'd2);
        nextCycle();
        checkOutput("pre_dfault", 32'(bus.double_fault), 32'd0);
        applyStimulus(5'b00010, 32'h0000_3000, 1'b0);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        checkOutput("df_set",        32'(bus.double_fault), 32'd1);
        checkOutput("df_cause",      32'(bus.cause),        32'd2);
        checkOutput("df_epc",        bus.epc,               32'h0000_1000);
        checkOutput("df_count",      32'(bus.exc_count),    32'd2);
        checkOutput("df_in_handler", 32'(bus.in_handler),   32'd1);
        applyStimulus(5'b0, 32'h0, 1'b1);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        checkOutput("df_ret_redirect", 32'(bus.pc_redirect), 32'd1);
        checkOutput("df_ret_pc",       bus.redirect_pc,      32'h0000_1000);
        nextCycle();
        checkOutput("df_sticky",       32'(bus.double_fault), 32'd1);
        checkOutput("df_idle_handler", 32'(bus.in_handler),   32'd0);

        $display("[TB] reset during redirect");
        applyStimulus(5'b00001, 32'h0000_5000, 1'b0);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        nextCycle();
        checkOutput("mid_redirect", 32'(bus.pc_redirect), 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("mr_flush",       32'(bus.flush),        32'd0);
        checkOutput("mr_pc_redirect", 32'(bus.pc_redirect),  32'd0);
        checkOutput("mr_redirect_pc", bus.redirect_pc,       32'd0);
        checkOutput("mr_epc",         bus.epc,               32'd0);
        checkOutput("mr_cause",       32'(bus.cause),        32'd0);
        checkOutput("mr_in_handler",  32'(bus.in_handler),   32'd0);
        checkOutput("mr_count",       32'(bus.exc_count),    32'd0);
        checkOutput("mr_dfault",      32'(bus.double_fault), 32'd0);
        nextCycle();
        checkOutput("mr_quiet_flush",    32'(bus.flush),       32'd0);
        checkOutput("mr_quiet_redirect", 32'(bus.pc_redirect), 32'd0);
        checkOutput("mr_quiet_handler",  32'(bus.in_handler),  32'd0);
        applyStimulus(5'b00010, 32'h0000_6000, 1'b0);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        checkOutput("post_rst_flush", 32'(bus.flush),     32'd1);
        checkOutput("post_rst_cause", 32'(bus.cause),     32'd4);
        checkOutput("post_rst_epc",   bus.epc,            32'h0000_6000);
        checkOutput("post_rst_count", 32'(bus.exc_count), 32'd1);

        $display("[TB] eret with simultaneous source");
        nextCycle();
        nextCycle();
        checkOutput("es_in_handler", 32'(bus.in_handler), 32'd1);
        applyStimulus(5'b01000, 32'h0000_7000, 1'b1);
        nextCycle();
        applyStimulus(5'b0, 32'h0, 1'b0);
        checkOutput("es_redirect",    32'(bus.pc_redirect),  32'd1);
        checkOutput("es_redirect_pc", bus.redirect_pc,       32'h0000_6000);
        checkOutput("es_dfault",      32'(bus.double_fault), 32'd1);
        checkOutput("es_cause",       32'(bus.cause),        32'd4);
        checkOutput("es_count",       32'(bus.exc_count),    32'd1);
        nextCycle();
        checkOutput("es_idle_handler",  32'(bus.in_handler),  32'd0);
        checkOutput("es_idle_redirect", 32'(bus.pc_redirect), 32'd0);

        $display("[TB] cause priority table and count saturation");
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        nextCycle();
        for (int i = 0; i < 7; i++) begin
            runEntry(tableSrc[i], 32'h0000_8000 + 32'(i * 4));
            checkOutput($sformatf("tbl%0d_cause", i), 32'(bus.cause), 32'(tableCause[i]));
            checkOutput($sformatf("tbl%0d_epc", i), bus.epc, 32'h0000_8000 + 32'(i * 4));
            checkOutput($sformatf("tbl%0d_count", i), 32'(bus.exc_count), 32'(i + 1));
        end
        for (int i = 7; i < 255; i++) begin
            runEntry(5'b00100, 32'h0000_9000);
        end
        checkOutput("count_255", 32'(bus.exc_count), 32'd255);
        runEntry(5'b00001, 32'h0000_A000);
        checkOutput("count_sat",     32'(bus.exc_count), 32'd255);
        checkOutput("count_sat_cau", 32'(bus.cause),     32'd5);
        checkOutput("count_sat_epc", bus.epc,            32'h0000_A000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
